// File: rtl/nes_bus_pkg.sv
// Shared CPU/PPU bus definitions: DMA FSM state encoding and the register
// addresses that both the OAM DMA engine and the PPU register decoder use.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_HALT,
      DMA_ALIGN,
      DMA_READ,
      DMA_WRITE
   } dma_state_t;

   localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine and CPU bus arbiter.
// While idle the CPU owns the bus. A CPU write to DMA_REG_ADDR freezes the CPU
// and copies XFER_LEN bytes from page {data,00} to OAM_DATA_ADDR, one
// read/write pair per byte, then hands the bus back.
// Optional build macro: OAM_DMA_ALIGN_EN inserts one ALIGN cycle after HALT
// whenever HALT falls on an odd cycle, so every READ starts on an even cycle.
module oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
   parameter int          XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   output logic        cpu_halt,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_we,
   input  logic [7:0]  bus_din,
   output logic        dma_busy
);

   localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

   dma_state_t  state;
   dma_state_t  state_next;
   logic [8:0]  idx;
   logic [7:0]  page;
   logic [7:0]  data_q;
   logic        parity;
   logic        trigger;
   logic        last_byte;

   assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
   assign last_byte = (idx == LAST_IDX);
   assign dma_busy  = (state != DMA_IDLE);

   // Next-state selection and bus ownership mux; reset forces passthrough so a
   // pending DMA write never reaches the bus in the reset cycle.
   always_comb begin
      state_next = state;
      bus_addr   = cpu_addr;
      bus_dout   = cpu_dout;
      bus_we     = cpu_we;
      if (rst) begin
         state_next = DMA_IDLE;
      end else begin
         case (state)
            DMA_IDLE: begin
               if (trigger) begin
                  state_next = DMA_HALT;
               end
            end
            DMA_HALT: begin
               bus_we = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
               state_next = parity ? DMA_ALIGN : DMA_READ;
`else
               state_next = DMA_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            DMA_ALIGN: begin
               bus_we     = 1'b0;
               state_next = DMA_READ;
            end
`endif
            DMA_READ: begin
               bus_addr   = {page, idx[7:0]};
               bus_dout   = data_q;
               bus_we     = 1'b0;
               state_next = DMA_WRITE;
            end
            DMA_WRITE: begin
               bus_addr   = OAM_DATA_ADDR;
               bus_dout   = data_q;
               bus_we     = 1'b1;
               state_next = last_byte ? DMA_IDLE : DMA_READ;
            end
            default: begin
               state_next = DMA_IDLE;
            end
         endcase
      end
   end

   // FSM state, byte index, source page, read latch, cycle parity and CPU halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DMA_IDLE;
         idx      <= '0;
         page     <= '0;
         data_q   <= '0;
         parity   <= 1'b0;
         cpu_halt <= 1'b0;
      end else begin
         state  <= state_next;
         parity <= ~parity;
         case (state)
            DMA_IDLE: begin
               if (trigger) begin
                  page     <= cpu_dout;
                  idx      <= '0;
                  cpu_halt <= 1'b1;
               end
            end
            DMA_READ: begin
               data_q <= bus_din;
            end
            DMA_WRITE: begin
               if (last_byte) begin
                  cpu_halt <= 1'b0;
               end else begin
                  idx <= idx + 9'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: passthrough, full 256-byte DMA,
// alignment (when OAM_DMA_ALIGN_EN is defined), reset abort, near-miss
// addresses, and a second instance built with XFER_LEN=1.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
   localparam int ALIGN_ON = 1;
`else
   localparam int ALIGN_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_we;
   logic        cpu_halt;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_we;
   logic [7:0]  bus_din;
   logic        dma_busy;

   logic [15:0] c1_addr;
   logic [7:0]  c1_dout;
   logic        c1_we;
   logic        c1_halt;
   logic [15:0] b1_addr;
   logic [7:0]  b1_dout;
   logic        b1_we;
   logic [7:0]  b1_din;
   logic        c1_busy;

   logic [7:0]  mem [0:65535];
   logic [7:0]  oam_log [$];
   logic [7:0]  oam_log1 [$];
   logic [15:0] reads1 [$];

   int          compared = 0;
   int          mismatched = 0;
   int unsigned cyc = 0;

   oam_dma u_dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_addr (cpu_addr),
      .cpu_dout (cpu_dout),
      .cpu_we   (cpu_we),
      .cpu_halt (cpu_halt),
      .bus_addr (bus_addr),
      .bus_dout (bus_dout),
      .bus_we   (bus_we),
      .bus_din  (bus_din),
      .dma_busy (dma_busy)
   );

   oam_dma #(.XFER_LEN(1)) u_dut_len1 (
      .clk      (clk),
      .rst      (rst),
      .cpu_addr (c1_addr),
      .cpu_dout (c1_dout),
      .cpu_we   (c1_we),
      .cpu_halt (c1_halt),
      .bus_addr (b1_addr),
      .bus_dout (b1_dout),
      .bus_we   (b1_we),
      .bus_din  (b1_din),
      .dma_busy (c1_busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   assign bus_din = mem[bus_addr];
   assign b1_din  = mem[b1_addr];

   // Cycle counter since reset; bit 0 is the expected even/odd parity.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Record every DMA write to the OAM data port and every DMA source read.
   always @(negedge clk) begin
      if (!rst && dma_busy && bus_we && bus_addr == 16'h2004) oam_log.push_back(bus_dout);
      if (!rst && c1_busy && b1_we && b1_addr == 16'h2004) oam_log1.push_back(b1_dout);
      if (!rst && c1_busy && !b1_we && b1_addr != c1_addr) reads1.push_back(b1_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic we);
      cpu_addr = a;
      cpu_dout = d;
      cpu_we   = we;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic measureHalt(output int n);
      n = 0;
      while (cpu_halt === 1'b1 && n < 1000) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int hp;
      logic [7:0] v;

      for (int i = 0; i < 256; i++) begin
         mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
         mem[16'h0400 + i] = 8'(i) ^ 8'h3C;
      end
      mem[16'h0700] = 8'h5C;

      applyStimulus(16'h0000, 8'h00, 1'b0);
      c1_addr = 16'h0000;
      c1_dout = 8'h00;
      c1_we   = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset state");
      applyStimulus(16'h1234, 8'hC3, 1'b0);
      #1;
      checkOutput("reset_halt", cpu_halt, 0);
      checkOutput("reset_busy", dma_busy, 0);
      checkOutput("reset_addr", bus_addr, 16'h1234);
      checkOutput("reset_dout", bus_dout, 8'hC3);
      checkOutput("reset_we", bus_we, 0);

      $display("[TB] idle passthrough");
      applyStimulus(16'h0200, 8'h5A, 1'b1);
      #1;
      checkOutput("pass_addr", bus_addr, 16'h0200);
      checkOutput("pass_dout", bus_dout, 8'h5A);
      checkOutput("pass_we", bus_we, 1);
      checkOutput("pass_halt", cpu_halt, 0);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      tick();

      $display("[TB] full DMA from page 03");
      oam_log.delete();
      applyStimulus(16'h4014, 8'h03, 1'b1);
      #1;
      checkOutput("trig_addr", bus_addr, 16'h4014);
      checkOutput("trig_dout", bus_dout, 8'h03);
      checkOutput("trig_we", bus_we, 1);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      #1;
      checkOutput("halt_halt", cpu_halt, 1);
      checkOutput("halt_busy", dma_busy, 1);
      checkOutput("halt_we", bus_we, 0);
      hp = int'(cyc[0]);
      measureHalt(n);
      checkOutput("full_halt_len", n, 513 + ALIGN_ON * hp);
      checkOutput("full_busy_end", dma_busy, 0);
      checkOutput("full_count", oam_log.size(), 256);
      for (int i = 0; i < 256; i++) begin
         v = (i < oam_log.size()) ? oam_log[i] : 8'hxx;
         checkOutput($sformatf("full_byte%0d", i), v, 8'(i) ^ 8'hA5);
      end

`ifdef OAM_DMA_ALIGN_EN
      $display("[TB] alignment: HALT on odd cycle");
      if (cyc[0] == 1'b1) tick();
      applyStimulus(16'h4014, 8'h03, 1'b1);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      #1;
      checkOutput("align_halt_parity", cyc[0], 1);
      measureHalt(n);
      checkOutput("align_halt_len", n, 514);
`endif

      $display("[TB] reset mid-transfer");
      tick();
      oam_log.delete();
      applyStimulus(16'h4014, 8'h03, 1'b1);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      n = 0;
      while (oam_log.size() < 10 && n < 100) begin
         tick();
         n++;
      end
      checkOutput("abort_reached10", n < 100, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(16'h1111, 8'h22, 1'b1);
      #1;
      checkOutput("abort_halt", cpu_halt, 0);
      checkOutput("abort_busy", dma_busy, 0);
      checkOutput("abort_addr", bus_addr, 16'h1111);
      checkOutput("abort_we", bus_we, 1);
      checkOutput("abort_count", oam_log.size(), 10);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      tick();
      oam_log.delete();
      applyStimulus(16'h4014, 8'h04, 1'b1);
      tick();
      applyStimulus(16'h0000, 8'h00, 1'b0);
      #1;
      hp = int'(cyc[0]);
      measureHalt(n);
      checkOutput("restart_halt_len", n, 513 + ALIGN_ON * hp);
      checkOutput("restart_count", oam_log.size(), 256);
      v = (oam_log.size() > 0) ? oam_log[0] : 8'hxx;
      checkOutput("restart_first", v, 8'h3C);
      v = (oam_log.size() > 255) ? oam_log[255] : 8'hxx;
      checkOutput("restart_last", v, 8'hC3);

      $display("[TB] near-miss addresses");
      applyStimulus(16'h4013, 8'h03, 1'b1);
      tick();
      checkOutput("miss4013_busy", dma_busy, 0);
      applyStimulus(16'h4015, 8'h03, 1'b1);
      tick();
      checkOutput("miss4015_busy", dma_busy, 0);
      applyStimulus(16'h4014, 8'h03, 1'b0);
      tick();
      checkOutput("read4014_busy", dma_busy, 0);
      checkOutput("read4014_halt", cpu_halt, 0);
      applyStimulus(16'h0000, 8'h00, 1'b0);
      tick();

      $display("[TB] XFER_LEN=1 instance");
      oam_log1.delete();
      reads1.delete();
      c1_addr = 16'h4014;
      c1_dout = 8'h07;
      c1_we   = 1'b1;
      tick();
      c1_addr = 16'h0000;
      c1_dout = 8'h00;
      c1_we   = 1'b0;
      #1;
      hp = int'(cyc[0]);
      n = 0;
      while (c1_halt === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      checkOutput("len1_halt_len", n, 3 + ALIGN_ON * hp);
      checkOutput("len1_busy_end", c1_busy, 0);
      checkOutput("len1_writes", oam_log1.size(), 1);
      v = (oam_log1.size() > 0) ? oam_log1[0] : 8'hxx;
      checkOutput("len1_data", v, 8'h5C);
      checkOutput("len1_reads", reads1.size(), 1);
      checkOutput("len1_read_addr", (reads1.size() > 0) ? reads1[0] : 16'hxxxx, 16'h0700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
